// File: rtl/rv32i_alu.sv
// Registered RV32I integer ALU: add/sub, compares, logic, shifts, pass-b; one-cycle latency.
// Optional registered zero flag enabled by defining ALU_ZERO_FLAG_EN.
module rv32i_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] res,
`ifdef ALU_ZERO_FLAG_EN
  output logic            zero,
`endif
  output logic            out_valid
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SLL   = 4'b0001,
    OP_SLT   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_AND   = 4'b0111,
    OP_SUB   = 4'b1000,
    OP_PASSB = 4'b1001,
    OP_SRA   = 4'b1101
  } alu_op_e;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] f;

  assign shamt = b[SHW-1:0];

  // Decode gated by in_valid so X on idle inputs never reaches the result mux.
  always_comb begin
    f = '0;
    if (in_valid) begin
      case (op)
        OP_ADD:   f = a + b;
        OP_SUB:   f = a - b;
        OP_SLT:   f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_SLTU:  f = {{(XLEN-1){1'b0}}, (a < b)};
        OP_XOR:   f = a ^ b;
        OP_OR:    f = a | b;
        OP_AND:   f = a & b;
        OP_SLL:   f = a << shamt;
        OP_SRL:   f = a >> shamt;
        OP_SRA:   f = $signed(a) >>> shamt;
        OP_PASSB: f = b;
        default:  f = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero      <= 1'b1;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res  <= f;
`ifdef ALU_ZERO_FLAG_EN
        zero <= (f == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench for rv32i_alu: directed vector tables plus a random stream.
module tb_rv32i_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic [31:0] res;
  logic        out_valid;
`ifdef ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv32i_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .res(res),
`ifdef ALU_ZERO_FLAG_EN
    .zero(zero),
`endif
    .out_valid(out_valid)
  );

  // Reference model written from the ISA definitions, not the RTL structure.
  function automatic logic [31:0] model(logic [31:0] ma, logic [31:0] mb, logic [3:0] mop);
    logic [63:0] ext;
    int sh;
    sh = int'(mb[4:0]);
    case (mop)
      4'b0000: return ma + mb;
      4'b1000: return ma + ~mb + 32'd1;
      4'b0010: return (ma[31] != mb[31]) ? {31'd0, ma[31]} : {31'd0, (ma < mb)};
      4'b0011: return {31'd0, (ma < mb)};
      4'b0100: return ma ^ mb;
      4'b0110: return ma | mb;
      4'b0111: return ma & mb;
      4'b0001: return ma << sh;
      4'b0101: return ma >> sh;
      4'b1101: begin ext = {{32{ma[31]}}, ma} >> sh; return ext[31:0]; end
      4'b1001: return mb;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 total++;
    if (res !== 32'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_init res=%h ov=%b want res=0 ov=0", res, out_valid);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; a = 32'd3; b = 32'd4; op = 4'b0000;
    @(posedge clk); #1 total++;
    if (res !== 32'd7 || out_valid !== 1'b1) begin
      bad++; $display("FAIL reset_pre res=%h ov=%b want res=7 ov=1", res, out_valid);
    end
    #2 rst_n = 1'b0;
    #1 total++;
    if (res !== 32'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async res=%h ov=%b want res=0 ov=0", res, out_valid);
    end
`ifdef ALU_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero zero=%b want 1", zero); end
`endif
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 total++;
    if (res !== 32'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hold res=%h ov=%b want res=0 ov=0", res, out_valid);
    end
  endtask

  // Each directed test: drive a table back-to-back, push expectations, pop one per cycle.
  task automatic run_table(string name, logic [31:0] ta[], logic [31:0] tb_[], logic [3:0] to[], logic [31:0] te[]);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < ta.size(); i++) begin
      @(negedge clk); in_valid = 1'b1; a = ta[i]; b = tb_[i]; op = to[i];
      exp_q.push_back(te[i]);
      @(posedge clk); #1 total++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || res !== e) begin
        bad++; $display("FAIL %s[%0d] res=%h ov=%b want res=%h ov=1", name, i, res, out_valid, e);
      end
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (zero !== (e == 32'd0)) begin
        bad++; $display("FAIL %s_zero[%0d] zero=%b want %b", name, i, zero, (e == 32'd0));
      end
`endif
    end
    @(negedge clk); in_valid = 1'b0; a = 'x; b = 'x; op = 'x;
    @(posedge clk); #1 total++;
    if (out_valid !== 1'b0 || res !== e) begin
      bad++; $display("FAIL %s_idle res=%h ov=%b want res=%h ov=0", name, res, out_valid, e);
    end
  endtask

  task automatic test_arith();
    run_table("arith", '{32'hFFFF_FFFF, 32'h0}, '{32'h1, 32'h1}, '{4'b0000, 4'b1000},
              '{32'h0, 32'hFFFF_FFFF});
  endtask

  task automatic test_compare();
    run_table("cmp", '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd4, 32'h7FFF_FFFF},
              '{32'h1, 32'h1, 32'd5, 32'd5, 32'd5, 32'h8000_0000},
              '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010},
              '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0});
  endtask

  task automatic test_shift();
    run_table("shift",
      '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
        32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001},
      '{32'h21, 32'h21, 32'h21, 32'h0, 32'h0, 32'h0, 32'h1F, 32'h1F, 32'h1F},
      '{4'b0001, 4'b0101, 4'b1101, 4'b0001, 4'b0101, 4'b1101, 4'b0001, 4'b0101, 4'b1101},
      '{32'h2, 32'h4000_0000, 32'hC000_0000, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
        32'h8000_0000, 32'h1, 32'hFFFF_FFFF});
  endtask

  task automatic test_logic();
    run_table("logic",
      '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
        32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0},
      '{32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0,
        32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0},
      '{4'b0100, 4'b0110, 4'b0111, 4'b1001, 4'b1111, 4'b1010, 4'b1011, 4'b1100, 4'b1110},
      '{32'hFF00_FF00, 32'hFFF0_FFF0, 32'h00F0_00F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0});
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      if (i % 7 == 0) b[4:0] = 5'd0;
      exp_q.push_back(model(a, b, op));
      @(posedge clk); #1 total++;
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || res !== e) begin
        bad++; $display("FAIL stream[%0d] op=%b res=%h ov=%b want res=%h ov=1", i, op, res, out_valid, e);
      end
`ifdef ALU_ZERO_FLAG_EN
      total++;
      if (zero !== (e == 32'd0)) begin
        bad++; $display("FAIL stream_zero[%0d] zero=%b want %b", i, zero, (e == 32'd0));
      end
`endif
      if (i == 500) begin
        @(negedge clk); in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'b0000;
        @(posedge clk); #1 total++;
        if (out_valid !== 1'b0 || res !== e) begin
          bad++; $display("FAIL stream_gap res=%h ov=%b want res=%h ov=0", res, out_valid, e);
        end
      end
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1 total++;
    if (out_valid !== 1'b0 || res !== e || exp_q.size() != 0) begin
      bad++; $display("FAIL stream_end res=%h ov=%b q=%0d want res=%h ov=0 q=0", res, out_valid, exp_q.size(), e);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_logic();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_alu.md
Name: rv32i_alu

Overview:
Registered RV32I integer ALU for the execute stage. It takes two XLEN-bit operands and a 4-bit operation code and computes add/sub, signed/unsigned compare, logic ops, shifts or pass-through of operand b. The result is registered with a one-cycle latency and a valid strobe.

Parameters:
XLEN, 32, operand/result width; must be a power of two >= 8; shift amount width SHW = clog2(XLEN) (5 at default).

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands/op valid this cycle; no backpressure.
a  input  XLEN  operand A (rs1 / PC).
b  input  XLEN  operand B (rs2 / immediate).
op  input  4  operation select.
res  output  XLEN  registered result.
out_valid  output  1  res updated this cycle (pulse per accepted input).
zero  output  1  only when ALU_ZERO_FLAG_EN defined; registered (res == 0).

Behaviour:
- Interface is fixed: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset asserted (any time, incl. mid-stream): res=0, out_valid=0, zero=1 immediately, without waiting for clk; any in-flight op is dropped.
- Rising clk with in_valid=1: res <= f(a,b,op), out_valid <= 1. Latency exactly 1 cycle; back-to-back inputs give one result per cycle.
- Rising clk with in_valid=0: out_valid <= 0; res (and zero) hold their previous value.
- f(a,b,op), all arithmetic modulo 2^XLEN, no overflow/carry outputs:
  0000 ADD: a + b.
  1000 SUB: a - b.
  0010 SLT: 1 if signed(a) < signed(b), else 0 (zero-extended).
  0011 SLTU: 1 if unsigned a < b, else 0.
  0100 XOR: a ^ b.
  0110 OR: a | b.
  0111 AND: a & b.
  0001 SLL: a << b[SHW-1:0]; upper bits of b ignored.
  0101 SRL: logical a >> b[SHW-1:0], zero fill.
  1101 SRA: arithmetic a >>> b[SHW-1:0], sign fill from a[XLEN-1].
  1001 PASSB: b (LUI).
  All other codes (1010,1011,1100,1110,1111): result 0.
- Shift by 0 returns a unchanged; shift by XLEN-1 is max.
- op is decoded only when in_valid=1; X on op/a/b while in_valid=0 must not propagate to res.

Optional Feature:
ALU_ZERO_FLAG_EN: when defined, adds output zero, registered together with res: set to (f(a,b,op)==0) on accepted inputs, holds otherwise, reset value 1. When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 asserted between clock edges -> res=0, out_valid=0 (zero=1) with no clk edge; release, in_valid=0 -> outputs hold.
- Arithmetic: a=0xFFFFFFFF,b=1,op=0000 -> res=0x00000000 next cycle, out_valid=1 for one cycle; a=0,b=1,op=1000 -> 0xFFFFFFFF.
- Compares: a=0xFFFFFFFF,b=1 op=0010 -> 1; op=0011 -> 0; a=b=5 either op -> 0.
- Shifts: a=0x80000001,b=0x00000021 (shamt 1): op=0001 -> 0x00000002, op=0101 -> 0x40000000, op=1101 -> 0xC0000000; b=0 -> res=a.
- Logic/pass/undefined: a=0xF0F0F0F0,b=0x0FF00FF0: XOR 0xFF00FF00, OR 0xFFF0FFF0, AND 0x00F000F0, op=1001 -> 0x0FF00FF0, op=1111 -> 0 (zero=1 if enabled).
- Streaming: 1000 random a,b,op with in_valid=1 every cycle -> each res matches software model one cycle later; drop in_valid for one cycle -> out_valid=0, res held.
